serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit per clock, LSB first, WIDTH cycles.
// Ports: clk, rst_n (sync, active-low), start/a/b/cin in; busy/done/sum/cout/ovf out.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic w_ai;
    logic w_bi;
    logic w_sbit;
    logic w_carry;
    logic w_last;

    // Operands shift right, so bit 0 is always the bit being added.
    assign w_ai    = r_a[0];
    assign w_bi    = r_b[0];
    assign w_sbit  = w_ai ^ w_bi ^ r_c;
    assign w_carry = (w_ai & w_bi) | (r_c & (w_ai ^ w_bi));
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_carry;
                    r_cnt <= r_cnt + CW'(1);
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_cnt == CW'(i)) begin
                            r_sum[i] <= w_sbit;
                        end
                    end
                    if (w_last) begin
                        // Carry into the MSB is r_c; carry out is w_carry.
                        r_cout  <= w_carry;
                        r_ovf   <= r_c ^ w_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
